// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and helpers for the RV64M multiply control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int XLEN = 64;

    // funct3[1:0] of the M-extension multiply group
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Magnitude of a two's complement value; -2^63 maps to 0x8000_0000_0000_0000,
    // which is exactly representable as an unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 64'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_sign_fixup.sv
`default_nettype none
// ============================================================================
// Module      : mul_sign_fixup
// Description : Conditional 128-bit negate of the unsigned array product and
//               selection of the low half, high half or sign-extended word.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sign_fixup
    import mul_pkg::*;
(
    input  logic [2*XLEN-1:0] p_i,
    input  logic              neg_i,
    input  logic [1:0]        op_i,
    input  logic              w_i,
    output logic [XLEN-1:0]   data_o
);

    logic [2*XLEN-1:0] p_fix;

    assign p_fix = neg_i ? (~p_i + 128'd1) : p_i;

    // Word ops take precedence over op so an illegal w with op != MUL acts as MULW
    always_comb begin
        data_o = p_fix[XLEN-1:0];
        if (w_i) begin
            data_o = {{32{p_fix[31]}}, p_fix[31:0]};
        end else if (op_i != 2'(OP_MUL)) begin
            data_o = p_fix[2*XLEN-1:XLEN];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_ctrl
// Description : Sequencing and sign handling around an external unsigned
//               64x64 array. Registers operand magnitudes, waits MUL_LATENCY
//               cycles for the array to settle, then fixes the sign and
//               selects the result half/word.
//               Optional macro MUL_ZERO_SKIP_EN: a zero operand (after MULW
//               truncation) completes after a single cycle with data 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic         req_w,
    input  logic [63:0]  req_a,
    input  logic [63:0]  req_b,
    input  logic [4:0]   req_rd,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [63:0]  resp_data,
    output logic [4:0]   resp_rd,
    output logic [63:0]  mul_a,
    output logic [63:0]  mul_b,
    input  logic [127:0] mul_p
);
    import mul_pkg::*;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_CALC   = ST_CALC;
    localparam logic [1:0] S_DONE   = ST_DONE;
    localparam logic [3:0] CNT_LAST = 4'(MUL_LATENCY - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mul_a_q, mul_b_q;
    logic            neg_q;
    logic [1:0]      op_q;
    logic            w_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] resp_data_q;
    logic [4:0]      resp_rd_q;
    logic            skip_q;

    logic            accept;
    logic            capture;
    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] opa, opb;
    logic [XLEN-1:0] fix_data;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

    // A flush in the same cycle as a request blocks acceptance
    assign accept  = req_valid && req_ready && !flush;
    assign capture = (state_q == S_CALC) && (state_d == S_DONE);

    // Operand conditioning: word ops are zero-extended unsigned; otherwise
    // signedness follows the op (MUL low bits are sign-agnostic)
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        opa   = req_a;
        opb   = req_b;
        if (req_w) begin
            opa = {32'd0, req_a[31:0]};
            opb = {32'd0, req_b[31:0]};
        end else begin
            sgn_a = (req_op == 2'(OP_MULH)) || (req_op == 2'(OP_MULHSU));
            sgn_b = (req_op == 2'(OP_MULH));
        end
    end

    // Next-state and settle counter; flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_CALC;
                    cnt_d   = 4'd0;
                end
            end
            S_CALC: begin
                if ((cnt_q == CNT_LAST) || skip_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand magnitudes and op attributes latched at accept; held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            neg_q   <= 1'b0;
            op_q    <= 2'd0;
            w_q     <= 1'b0;
            rd_q    <= 5'd0;
        end else if (accept) begin
            mul_a_q <= mag(opa, sgn_a);
            mul_b_q <= mag(opb, sgn_b);
            neg_q   <= (sgn_a & req_a[XLEN-1]) ^ (sgn_b & req_b[XLEN-1]);
            op_q    <= req_op;
            w_q     <= req_w;
            rd_q    <= req_rd;
        end
    end

`ifdef MUL_ZERO_SKIP_EN
    // Remember a zero operand so CALC can finish after one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= 1'b0;
        end else if (accept) begin
            skip_q <= (opa == '0) || (opb == '0);
        end
    end
`else
    assign skip_q = 1'b0;
`endif

    mul_sign_fixup u_fixup (
        .p_i    (mul_p),
        .neg_i  (neg_q),
        .op_i   (op_q),
        .w_i    (w_q),
        .data_o (fix_data)
    );

    // Result registers load once on entering DONE and hold through backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q <= '0;
            resp_rd_q   <= 5'd0;
        end else if (capture) begin
            resp_data_q <= skip_q ? '0 : fix_data;
            resp_rd_q   <= rd_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_unit_ctrl
// Description : Self-checking bench for mul_unit_ctrl with a behavioural
//               array model and a signed-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_unit_ctrl;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'd0;
    logic         req_w = 1'b0;
    logic [63:0]  req_a = '0;
    logic [63:0]  req_b = '0;
    logic [4:0]   req_rd = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [63:0]  resp_data;
    logic [4:0]   resp_rd;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [127:0] mul_p;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Unsigned array stand-in
    assign mul_p = {64'd0, mul_a} * {64'd0, mul_b};

    mul_unit_ctrl #(.MUL_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_w      (req_w),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result from signed arithmetic on sign/zero-extended operands
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] ea, eb, pr;
        logic [63:0] lo;
        if (w) begin
            lo = {32'd0, a[31:0]} * {32'd0, b[31:0]};
            return {{32{lo[31]}}, lo[31:0]};
        end
        ea = (op == 2'b01 || op == 2'b10) ? {{66{a[63]}}, a} : {66'd0, a};
        eb = (op == 2'b01) ? {{66{b[63]}}, b} : {66'd0, b};
        pr = ea * eb;
        return (op == 2'b00) ? pr[63:0] : pr[127:64];
    endfunction

    function automatic logic [63:0] ref_mag(input logic w, input logic sgn, input logic [63:0] v);
        if (w) return {32'd0, v[31:0]};
        if (sgn && $signed(v) < 0) return 64'(-$signed(v));
        return v;
    endfunction

    function automatic int ref_lat(input logic w, input logic [63:0] a, input logic [63:0] b);
        logic z;
        z = w ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
`ifdef MUL_ZERO_SKIP_EN
        return z ? 1 : LAT;
`else
        if (z) return LAT;
        return LAT;
`endif
    endfunction

    // Drive one request for a single cycle; accept happens at the posedge
    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_w = w; req_a = a; req_b = b; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full transaction: latency, result, tag, magnitudes, backpressure hold
    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input int hold);
        logic [63:0] exp;
        int lat;
        exp = ref_mul(op, w, a, b);
        check("ready_before", 64'(req_ready), 64'd1);
        send(op, w, a, b, rd);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(ref_lat(w, a, b)));
        check("data", resp_data, exp);
        check("rd", 64'(resp_rd), 64'(rd));
        check("mag_a", mul_a, ref_mag(w, !w && (op == 2'b01 || op == 2'b10), a));
        check("mag_b", mul_b, ref_mag(w, !w && op == 2'b01, b));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", resp_data, exp);
            check("hold_rd", 64'(resp_rd), 64'(rd));
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        check("ready_in_done", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_after_xfer", 64'(resp_valid), 64'd0);
        check("ready_after_xfer", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;

        // Reset values
        #12;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_data", resp_data, 64'd0);
        check("rst_rd", 64'(resp_rd), 64'd0);
        check("rst_mul_a", mul_a, 64'd0);
        check("rst_mul_b", mul_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 0);
        run_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 0);
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5, 0);
        run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 0);
        run_op(2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd7, 0);
        run_op(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd7, 5'd8, 5);
        run_op(2'b00, 1'b0, 64'd0, 64'd5, 5'd9, 0);
        run_op(2'b11, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h1234_5678_FFFF_FFFF, 5'd10, 1);

        // Flush in CALC: no response, idle next cycle
        send(2'b00, 1'b0, 64'd1234, 64'd99, 5'd11);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_ready", 64'(req_ready), 64'd1);
        check("flush_calc_valid", 64'(resp_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("flush_calc_noresp", 64'(seen), 64'd0);

        // Flush together with a request in IDLE: nothing accepted
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_w = 1'b0;
        req_a = 64'd777; req_b = 64'd3; req_rd = 5'd12;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle_ready", 64'(req_ready), 64'd1);
        check("flush_idle_mul_a", mul_a, 64'd1234);
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("flush_idle_noresp", 64'(seen), 64'd0);

        // Asynchronous reset mid-operation
        send(2'b01, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5'd13);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(req_ready), 64'd1);
        check("arst_valid", 64'(resp_valid), 64'd0);
        check("arst_mul_a", mul_a, 64'd0);
        check("arst_mul_b", mul_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("arst_noresp", 64'(seen), 64'd0);

        // Randomized operations against the reference
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            w  = (op == 2'b00) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 5))
                    0:       a = 64'd0;
                    1:       a = 64'hFFFF_FFFF_FFFF_FFFF;
                    2:       a = 64'h8000_0000_0000_0000;
                    3:       a = {32'd0, $urandom};
                    default: a = {$urandom, $urandom};
                endcase
                if (k == 0) b = a;
            end
            run_op(op, w, a, b, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
